mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL be the maximum number of REQ-state cycles to wait for mem_ack (legal 2..255).
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 MemRead_in, MemWrite_in  input  1 each  EX/MEM-stage access request flags.
REQ-005 BHW_in  input  2  access size: 00 word, 01 halfword, 10 byte, 11 word.
REQ-006 DataMemExtendSign_in  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
REQ-007 ALUResult_in  input  32  byte address; ReadData2_in  input  32  store data.
REQ-008 mem_req  output  1  memory request, level, held until ack or timeout.
REQ-009 mem_we  output  1  1 = write; mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-010 mem_be  output  4  byte enables; mem_wdata  output  32  lane-replicated store data.
REQ-011 mem_ack  input  1  one-cycle completion; mem_rdata  input  32  read word, valid with mem_ack.
REQ-012 Stall_out  output  1  1 = pipeline registers SHALL hold.
REQ-013 LoadData_out  output  32  extended load result; Timeout_out, Misaligned_out  output  1 each  one-cycle error pulses.

Function
REQ-014 States SHALL be IDLE, REQ, DONE.
REQ-015 Access valid = MemRead_in | MemWrite_in; both set SHALL be treated as a write.
REQ-016 Misaligned = (BHW_in=01 & addr[0]) | (BHW_in in {00,11} & addr[1:0]!=0).
REQ-017 IDLE, valid & aligned: Stall_out=1 combinationally; at edge latch addr, size, sign, write flag, store data; go REQ.
REQ-018 IDLE, valid & misaligned: no request, Stall_out=0, Misaligned_out=1 for that cycle, stay IDLE.
REQ-019 REQ: mem_req=1, Stall_out=1; mem_addr/mem_we/mem_be/mem_wdata SHALL be stable from latched values for the whole state.
REQ-020 mem_be: word 1111; halfword addr[1]?1100:0011; byte 0001<<addr[1:0]; reads use the same mapping.
REQ-021 mem_wdata: word as-is; halfword {2{d[15:0]}}; byte {4{d[7:0]}}.
REQ-022 REQ with mem_ack=1: load selected lane into LoadData_out (extended per latched sign bit; word unchanged; writes load 0); go DONE.
REQ-023 REQ cycle counter SHALL start at 1 on entry; when counter=TIMEOUT and no ack: drop mem_req, LoadData_out=0, Timeout_out=1 in DONE, go DONE.
REQ-024 Ack in the same cycle the counter reaches TIMEOUT SHALL count as success, no timeout.
REQ-025 DONE: Stall_out=0, mem_req=0, LoadData_out valid; go IDLE unconditionally (pipeline advances at this edge).
REQ-026 LoadData_out SHALL hold its value until the next DONE.
REQ-027 mem_ack outside REQ SHALL be ignored; mem_rdata SHALL be sampled only with ack in REQ.
REQ-028 Minimum latency: aligned access with ack in first REQ cycle = 3 cycles IDLE->REQ->DONE, stall 2 cycles.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, counter 0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, LoadData_out=0, Timeout_out=0, Misaligned_out=0, latched fields 0.
REQ-030 Stall_out SHALL be 0 during reset regardless of inputs; reset mid-REQ SHALL abandon the access with no DONE.
REQ-031 After rst returns to 1, first edge SHALL evaluate inputs from IDLE.

Verification
REQ-032 Byte load addr 0x1003, sign=1, rdata 0x80FFFFFF, ack 1st REQ cycle -> be=1000, LoadData_out=0xFFFFFF80, stall 2 cycles.
REQ-033 Halfword store addr 0x2002, data 0x0000BEEF, ack after 4 cycles -> be=1100, wdata=0xBEEFBEEF, mem_we=1, signals stable 4 cycles, stall 5 cycles.
REQ-034 Word load addr 0x3001 -> Misaligned_out=1 one cycle, mem_req never asserted, Stall_out=0.
REQ-035 Word load, no ack, TIMEOUT=16 -> mem_req high exactly 16 cycles, Timeout_out=1 in DONE, LoadData_out=0.
REQ-036 rst=0 mid-REQ (cycle 3) -> mem_req and Stall_out 0 same cycle; next aligned access after release served normally.
REQ-037 MemRead_in=MemWrite_in=1, byte addr 0x4001, data 0xA5 -> write issued, be=0010, wdata=0xA5A5A5A5.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: word-wide request/acknowledge memory bus.
// Ports (signals):
//   mem_req   level request, held until ack or timeout
//   mem_we    1 = write
//   mem_addr  word-aligned byte address
//   mem_be    byte enables
//   mem_wdata lane-replicated store data
//   mem_ack   one-cycle completion from memory
//   mem_rdata read word, valid with mem_ack
// Modports: master (controller side), slave (memory side).
interface mem_access_ctrl_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport master (output mem_req, mem_we, mem_addr, mem_be, mem_wdata, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_we, mem_addr, mem_be, mem_wdata, output mem_ack, mem_rdata);
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: stalls the pipeline while one load/store is carried out over a req/ack memory bus.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   MemRead_in, MemWrite_in  access request flags (both set = write)
//   BHW_in                   size: 00 word, 01 halfword, 10 byte, 11 word
//   DataMemExtendSign_in     1 = sign-extend sub-word loads
//   ALUResult_in             byte address
//   ReadData2_in             store data
//   mem                      memory bus (master side)
//   Stall_out                pipeline hold
//   LoadData_out             extended load result, held until the next completion
//   Timeout_out              one-cycle pulse in DONE after an unacknowledged request
//   Misaligned_out           one-cycle pulse for a rejected misaligned access
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic [1:0]        BHW_in,
  input  logic              DataMemExtendSign_in,
  input  logic [31:0]       ALUResult_in,
  input  logic [31:0]       ReadData2_in,
  mem_access_ctrl_if.master mem,
  output logic              Stall_out,
  output logic [31:0]       LoadData_out,
  output logic              Timeout_out,
  output logic              Misaligned_out
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      state, nextState;
  logic [7:0]  cnt;
  logic [31:0] addrReg, wdataReg;
  logic [3:0]  beReg;
  logic [1:0]  sizeReg;
  logic        signReg, writeReg;
  logic        valid, misaligned, start, timedOut;
  logic [3:0]  beNext;
  logic [31:0] wdataNext, loadNext;
  logic [7:0]  laneByte;
  logic [15:0] laneHalf;
  assign valid      = MemRead_in | MemWrite_in;
  assign misaligned = (BHW_in == 2'b01 && ALUResult_in[0]) ||
                      ((BHW_in == 2'b00 || BHW_in == 2'b11) && ALUResult_in[1:0] != 2'b00);
  assign beNext    = BHW_in == 2'b01 ? (ALUResult_in[1] ? 4'b1100 : 4'b0011) :
                     BHW_in == 2'b10 ? 4'b0001 << ALUResult_in[1:0] : 4'b1111;
  assign wdataNext = BHW_in == 2'b01 ? {2{ReadData2_in[15:0]}} :
                     BHW_in == 2'b10 ? {4{ReadData2_in[7:0]}} : ReadData2_in;
  // Lane selection uses the latched address so the result matches the issued request.
  assign laneByte = mem.mem_rdata[{addrReg[1:0], 3'b000} +: 8];
  assign laneHalf = addrReg[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
  assign loadNext = writeReg          ? 32'd0 :
                    sizeReg == 2'b10  ? {{24{signReg & laneByte[7]}}, laneByte} :
                    sizeReg == 2'b01  ? {{16{signReg & laneHalf[15]}}, laneHalf} : mem.mem_rdata;
  always_comb begin
    nextState = state;
    start     = 1'b0;
    timedOut  = 1'b0;
    case (state)
      IDLE: begin
        start     = valid && !misaligned;
        nextState = start ? REQ : IDLE;
      end
      REQ: begin
        // An ack on the final counted cycle still wins over the timeout.
        timedOut  = !mem.mem_ack && cnt == TIMEOUT[7:0];
        nextState = (mem.mem_ack || timedOut) ? DONE : REQ;
      end
      default: nextState = IDLE;
    endcase
  end
  // Gated by rst so nothing combinational leaks out while reset is held.
  assign Stall_out      = rst && (state == REQ || start);
  assign Misaligned_out = rst && state == IDLE && valid && misaligned;
  assign mem.mem_req    = state == REQ;
  assign mem.mem_we     = state == REQ && writeReg;
  assign mem.mem_be     = state == REQ ? beReg : 4'b0000;
  assign mem.mem_addr   = {addrReg[31:2], 2'b00};
  assign mem.mem_wdata  = wdataReg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nextState;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= 8'd0;
      addrReg      <= 32'd0;
      wdataReg     <= 32'd0;
      beReg        <= 4'b0000;
      sizeReg      <= 2'b00;
      signReg      <= 1'b0;
      writeReg     <= 1'b0;
      LoadData_out <= 32'd0;
      Timeout_out  <= 1'b0;
    end else begin
      if (start) begin
        addrReg  <= ALUResult_in;
        wdataReg <= wdataNext;
        beReg    <= beNext;
        sizeReg  <= BHW_in;
        signReg  <= DataMemExtendSign_in;
        writeReg <= MemWrite_in;
      end
      cnt <= start ? 8'd1 : (state == REQ && nextState == REQ) ? cnt + 8'd1 : 8'd0;
      if (state == REQ && mem.mem_ack) LoadData_out <= loadNext;
      else if (timedOut) LoadData_out <= 32'd0;
      Timeout_out <= timedOut;
    end
  end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl.
module tb_mem_access_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemRead_in, MemWrite_in, DataMemExtendSign_in;
  logic [1:0]  BHW_in;
  logic [31:0] ALUResult_in, ReadData2_in;
  logic        Stall_out, Timeout_out, Misaligned_out;
  logic [31:0] LoadData_out;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  mem_access_ctrl_if mif();
  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in), .BHW_in(BHW_in),
    .DataMemExtendSign_in(DataMemExtendSign_in),
    .ALUResult_in(ALUResult_in), .ReadData2_in(ReadData2_in),
    .mem(mif),
    .Stall_out(Stall_out), .LoadData_out(LoadData_out),
    .Timeout_out(Timeout_out), .Misaligned_out(Misaligned_out)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic rd, input logic wr, input logic [1:0] bhw, input logic sg,
                       input logic [31:0] a, input logic [31:0] d);
    MemRead_in = rd; MemWrite_in = wr; BHW_in = bhw; DataMemExtendSign_in = sg;
    ALUResult_in = a; ReadData2_in = d;
  endtask
  task automatic test_reset;
    rst = 1'b0;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1000, 32'hFFFF_FFFF);
    tick; #1;
    compared++; if (Stall_out !== 1'b0) begin mismatched++; $display("FAIL reset_stall: got %b want 0", Stall_out); end
    compared++; if (mif.mem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req: got %b want 0", mif.mem_req); end
    compared++; if (mif.mem_be !== 4'b0000) begin mismatched++; $display("FAIL reset_be: got %b want 0000", mif.mem_be); end
    compared++; if (mif.mem_addr !== 32'd0) begin mismatched++; $display("FAIL reset_addr: got %h want 0", mif.mem_addr); end
    compared++; if (mif.mem_wdata !== 32'd0) begin mismatched++; $display("FAIL reset_wdata: got %h want 0", mif.mem_wdata); end
    compared++; if (mif.mem_we !== 1'b0) begin mismatched++; $display("FAIL reset_we: got %b want 0", mif.mem_we); end
    compared++; if (LoadData_out !== 32'd0) begin mismatched++; $display("FAIL reset_load: got %h want 0", LoadData_out); end
    compared++; if (Timeout_out !== 1'b0) begin mismatched++; $display("FAIL reset_timeout: got %b want 0", Timeout_out); end
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1001, 32'd0);
    #1;
    compared++; if (Misaligned_out !== 1'b0) begin mismatched++; $display("FAIL reset_misaligned: got %b want 0", Misaligned_out); end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'd0;
    #1 rst = 1'b1;
  endtask
  task automatic test_byte_load;
    int stalls;
    drive(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'd0);
    #1 stalls = int'(Stall_out);
    compared++; if (mif.mem_req !== 1'b0) begin mismatched++; $display("FAIL bl_req_idle: got %b want 0", mif.mem_req); end
    tick;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h80FF_FFFF;
    #1 stalls += int'(Stall_out);
    compared++; if (mif.mem_req !== 1'b1) begin mismatched++; $display("FAIL bl_req: got %b want 1", mif.mem_req); end
    compared++; if (mif.mem_be !== 4'b1000) begin mismatched++; $display("FAIL bl_be: got %b want 1000", mif.mem_be); end
    compared++; if (mif.mem_addr !== 32'h0000_1000) begin mismatched++; $display("FAIL bl_addr: got %h want 00001000", mif.mem_addr); end
    compared++; if (mif.mem_we !== 1'b0) begin mismatched++; $display("FAIL bl_we: got %b want 0", mif.mem_we); end
    tick;
    mif.mem_ack = 1'b0; mif.mem_rdata = 32'hDEAD_BEEF;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #1 stalls += int'(Stall_out);
    compared++; if (LoadData_out !== 32'hFFFF_FF80) begin mismatched++; $display("FAIL bl_load: got %h want ffffff80", LoadData_out); end
    compared++; if (stalls != 2) begin mismatched++; $display("FAIL bl_stall_cycles: got %0d want 2", stalls); end
    compared++; if (mif.mem_req !== 1'b0) begin mismatched++; $display("FAIL bl_req_done: got %b want 0", mif.mem_req); end
    tick; #1;
    compared++; if (LoadData_out !== 32'hFFFF_FF80) begin mismatched++; $display("FAIL bl_load_hold: got %h want ffffff80", LoadData_out); end
  endtask
  task automatic test_timeout;
    int reqCycles = 0;
    logic found = 1'b0;
    drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_5000, 32'd0);
    for (int i = 0; i < 30 && !found; i++) begin
      tick; #1;
      if (mif.mem_req) reqCycles++;
      if (Timeout_out) begin
        found = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
        compared++; if (LoadData_out !== 32'd0) begin mismatched++; $display("FAIL to_load: got %h want 0", LoadData_out); end
        compared++; if (Stall_out !== 1'b0) begin mismatched++; $display("FAIL to_stall_done: got %b want 0", Stall_out); end
        compared++; if (mif.mem_req !== 1'b0) begin mismatched++; $display("FAIL to_req_done: got %b want 0", mif.mem_req); end
      end
    end
    compared++; if (found !== 1'b1) begin mismatched++; $display("FAIL to_pulse_seen: got %b want 1", found); end
    compared++; if (reqCycles != 16) begin mismatched++; $display("FAIL to_req_cycles: got %0d want 16", reqCycles); end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    tick; #1;
    compared++; if (Timeout_out !== 1'b0) begin mismatched++; $display("FAIL to_pulse_len: got %b want 0", Timeout_out); end
  endtask
  task automatic test_halfword_load;
    logic [31:0] addrs [3] = '{32'h0000_8002, 32'h0000_8000, 32'h0000_8101};
    logic [1:0]  sizes [3] = '{2'b01, 2'b01, 2'b10};
    logic        signs [3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] rdata [3] = '{32'h8001_1234, 32'h1234_9ABC, 32'h0000_F000};
    logic [3:0]  bes   [3] = '{4'b1100, 4'b0011, 4'b0010};
    logic [31:0] loads [3] = '{32'h0000_8001, 32'hFFFF_9ABC, 32'h0000_00F0};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, sizes[i], signs[i], addrs[i], 32'd0);
      tick;
      mif.mem_ack = 1'b1; mif.mem_rdata = rdata[i];
      #1;
      compared++; if (mif.mem_be !== bes[i]) begin mismatched++; $display("FAIL ld%0d_be: got %b want %b", i, mif.mem_be, bes[i]); end
      tick;
      mif.mem_ack = 1'b0;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
      #1;
      compared++; if (LoadData_out !== loads[i]) begin mismatched++; $display("FAIL ld%0d_load: got %h want %h", i, LoadData_out, loads[i]); end
      tick;
    end
  endtask
  task automatic test_half_store;
    int stalls;
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_BEEF);
    #1 stalls = int'(Stall_out);
    for (int i = 1; i <= 4; i++) begin
      tick;
      if (i == 4) begin mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF; end
      #1 stalls += int'(Stall_out);
      compared++; if (mif.mem_req !== 1'b1) begin mismatched++; $display("FAIL hs%0d_req: got %b want 1", i, mif.mem_req); end
      compared++; if (mif.mem_we !== 1'b1) begin mismatched++; $display("FAIL hs%0d_we: got %b want 1", i, mif.mem_we); end
      compared++; if (mif.mem_be !== 4'b1100) begin mismatched++; $display("FAIL hs%0d_be: got %b want 1100", i, mif.mem_be); end
      compared++; if (mif.mem_wdata !== 32'hBEEF_BEEF) begin mismatched++; $display("FAIL hs%0d_wdata: got %h want beefbeef", i, mif.mem_wdata); end
      compared++; if (mif.mem_addr !== 32'h0000_2000) begin mismatched++; $display("FAIL hs%0d_addr: got %h want 00002000", i, mif.mem_addr); end
    end
    tick;
    mif.mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #1 stalls += int'(Stall_out);
    compared++; if (stalls != 5) begin mismatched++; $display("FAIL hs_stall_cycles: got %0d want 5", stalls); end
    compared++; if (LoadData_out !== 32'd0) begin mismatched++; $display("FAIL hs_load: got %h want 0", LoadData_out); end
    compared++; if (mif.mem_we !== 1'b0) begin mismatched++; $display("FAIL hs_we_done: got %b want 0", mif.mem_we); end
    tick;
  endtask
  task automatic test_misaligned;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_3001, 32'd0);
    #1;
    compared++; if (Misaligned_out !== 1'b1) begin mismatched++; $display("FAIL mw_flag: got %b want 1", Misaligned_out); end
    compared++; if (Stall_out !== 1'b0) begin mismatched++; $display("FAIL mw_stall: got %b want 0", Stall_out); end
    tick;
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_3003, 32'd0);
    #1;
    compared++; if (mif.mem_req !== 1'b0) begin mismatched++; $display("FAIL mw_req: got %b want 0", mif.mem_req); end
    compared++; if (Misaligned_out !== 1'b1) begin mismatched++; $display("FAIL mh_flag: got %b want 1", Misaligned_out); end
    tick;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #1;
    compared++; if (mif.mem_req !== 1'b0) begin mismatched++; $display("FAIL mh_req: got %b want 0", mif.mem_req); end
    compared++; if (Misaligned_out !== 1'b0) begin mismatched++; $display("FAIL m_flag_clear: got %b want 0", Misaligned_out); end
  endtask
  task automatic test_ack_at_timeout;
    int reqCycles = 0;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_6000, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      tick;
      if (i == 16) begin mif.mem_ack = 1'b1; mif.mem_rdata = 32'h1234_5678; end
      #1 reqCycles += int'(mif.mem_req);
    end
    tick;
    mif.mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #1;
    compared++; if (reqCycles != 16) begin mismatched++; $display("FAIL at_req_cycles: got %0d want 16", reqCycles); end
    compared++; if (Timeout_out !== 1'b0) begin mismatched++; $display("FAIL at_timeout: got %b want 0", Timeout_out); end
    compared++; if (LoadData_out !== 32'h1234_5678) begin mismatched++; $display("FAIL at_load: got %h want 12345678", LoadData_out); end
    tick;
  endtask
  task automatic test_reset_mid_req;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_7000, 32'd0);
    tick; tick; tick; #1;
    compared++; if (mif.mem_req !== 1'b1) begin mismatched++; $display("FAIL rm_req_before: got %b want 1", mif.mem_req); end
    rst = 1'b0;
    #1;
    compared++; if (mif.mem_req !== 1'b0) begin mismatched++; $display("FAIL rm_req: got %b want 0", mif.mem_req); end
    compared++; if (Stall_out !== 1'b0) begin mismatched++; $display("FAIL rm_stall: got %b want 0", Stall_out); end
    compared++; if (LoadData_out !== 32'd0) begin mismatched++; $display("FAIL rm_load: got %h want 0", LoadData_out); end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #1 rst = 1'b1;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'h5555_5555;
    tick; #1;
    compared++; if (Stall_out !== 1'b0) begin mismatched++; $display("FAIL rm_no_done_stall: got %b want 0", Stall_out); end
    tick;
    mif.mem_ack = 1'b0;
    #1;
    compared++; if (LoadData_out !== 32'd0) begin mismatched++; $display("FAIL rm_stray_ack: got %h want 0", LoadData_out); end
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_7004, 32'd0);
    tick;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hCAFE_F00D;
    #1;
    compared++; if (mif.mem_addr !== 32'h0000_7004) begin mismatched++; $display("FAIL rm_next_addr: got %h want 00007004", mif.mem_addr); end
    compared++; if (mif.mem_be !== 4'b1111) begin mismatched++; $display("FAIL rm_next_be: got %b want 1111", mif.mem_be); end
    tick;
    mif.mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #1;
    compared++; if (LoadData_out !== 32'hCAFE_F00D) begin mismatched++; $display("FAIL rm_next_load: got %h want cafef00d", LoadData_out); end
    tick;
  endtask
  task automatic test_both_flags;
    drive(1'b1, 1'b1, 2'b10, 1'b1, 32'h0000_4001, 32'h0000_00A5);
    #1;
    compared++; if (Stall_out !== 1'b1) begin mismatched++; $display("FAIL bf_stall: got %b want 1", Stall_out); end
    tick;
    mif.mem_ack = 1'b1; mif.mem_rdata = 32'hFFFF_FFFF;
    #1;
    compared++; if (mif.mem_we !== 1'b1) begin mismatched++; $display("FAIL bf_we: got %b want 1", mif.mem_we); end
    compared++; if (mif.mem_be !== 4'b0010) begin mismatched++; $display("FAIL bf_be: got %b want 0010", mif.mem_be); end
    compared++; if (mif.mem_wdata !== 32'hA5A5_A5A5) begin mismatched++; $display("FAIL bf_wdata: got %h want a5a5a5a5", mif.mem_wdata); end
    compared++; if (mif.mem_addr !== 32'h0000_4000) begin mismatched++; $display("FAIL bf_addr: got %h want 00004000", mif.mem_addr); end
    tick;
    mif.mem_ack = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    #1;
    compared++; if (LoadData_out !== 32'd0) begin mismatched++; $display("FAIL bf_load: got %h want 0", LoadData_out); end
    tick;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    mif.mem_ack = 1'b0;
    mif.mem_rdata = 32'd0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0);
    test_reset;
    test_byte_load;
    test_timeout;
    test_halfword_load;
    test_half_store;
    test_misaligned;
    test_ack_at_timeout;
    test_reset_mid_req;
    test_both_flags;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
